// File: rtl/spi_slave.sv
// SPI mode-1 (CPOL=0, CPHA=1) responder, MSB first, oversampled in clk; pin edge to internal strobe is 3 clk.
// No backpressure: rx_valid is an unacknowledged pulse, tx_load is ignored while the holding register is full.
module spi_slave #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic              active,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Index 0/1 are the synchroniser flops; index 2 only feeds edge detection.
    logic [2:0] sclk_sr;
    logic [2:0] ss_sr;
    logic [1:0] mosi_sr;

    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic mosi_s;

    state_t            state;
    logic [CW-1:0]     bitcnt;
    logic [DWIDTH-1:0] holding;
    logic [DWIDTH-2:0] tx_shift;
    logic [DWIDTH-2:0] rx_shift;
    logic [DWIDTH-1:0] rx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sr <= 3'b000;
            ss_sr   <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            ss_sr   <= {ss_sr[1:0], ss_n};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign ss_fall   = ~ss_sr[1] & ss_sr[2];
    assign ss_rise   = ss_sr[1] & ~ss_sr[2];
    assign mosi_s    = mosi_sr[1];
    assign rx_next   = {rx_shift, mosi_s};

    // tx_shift holds only the bits still to be sent; the MSB goes straight to miso at fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitcnt   <= '0;
            holding  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            active   <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (tx_load && tx_ready) begin
                holding  <= tx_data;
                tx_ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= ACTIVE;
                        active  <= 1'b1;
                        miso_oe <= 1'b1;
                        miso    <= 1'b0;
                        bitcnt  <= '0;
                    end
                end

                ACTIVE: begin
                    if (ss_rise) begin
                        // Abort: drop any partial word without a strobe.
                        state    <= IDLE;
                        active   <= 1'b0;
                        miso_oe  <= 1'b0;
                        miso     <= 1'b0;
                        bitcnt   <= '0;
                        rx_shift <= '0;
                    end else begin
                        if (sclk_rise) begin
                            if (bitcnt == '0) begin
                                if (!tx_ready) begin
                                    tx_shift <= holding[DWIDTH-2:0];
                                    miso     <= holding[DWIDTH-1];
                                    tx_ready <= 1'b1;
                                end else begin
                                    tx_shift <= '0;
                                    miso     <= 1'b0;
                                    underrun <= 1'b1;
                                end
                            end else begin
                                miso     <= tx_shift[DWIDTH-2];
                                tx_shift <= tx_shift << 1;
                            end
                        end

                        if (sclk_fall) begin
                            rx_shift <= rx_next[DWIDTH-2:0];
                            if (bitcnt == LAST_BIT) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                bitcnt   <= '0;
                            end else begin
                                bitcnt <= bitcnt + CW'(1);
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-1 SPI master at clk = 8x sclk with hand-computed expectations.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       underrun_clr = 1'b0;
    logic       active;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] mi;

    spi_slave #(.DWIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .underrun    (underrun),
        .underrun_clr(underrun_clr),
        .active      (active),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rxw(input int k);
        if (k < rx_q.size()) return {24'h0, rx_q[k]};
        return 32'hDEAD;
    endfunction

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ss_low();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        @(negedge clk);
    endtask

    // Master drives mosi on the rising sclk edge and samples miso on the falling edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit do_load,
                            input logic [7:0] ld, input bit do_clr, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b1;
            mosi = mo[i];
            repeat (2) @(negedge clk);
            if (do_clr && i == 7) underrun_clr = 1'b1;
            @(negedge clk);
            underrun_clr = 1'b0;
            @(negedge clk);
            rd[i] = miso;
            sclk = 1'b0;
            if (do_load && i == 7) begin
                tx_data = ld;
                tx_load = 1'b1;
            end
            @(negedge clk);
            tx_load = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst tx_ready", tx_ready, 1);
        check("rst rx_data", rx_data, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst underrun", underrun, 0);
        check("rst active", active, 0);
        check("rst miso", miso, 0);
        check("rst miso_oe", miso_oe, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single word
        load(8'hA5);
        check("t1 tx_ready after load", tx_ready, 0);
        rx_q.delete();
        ss_low();
        check("t1 active", active, 1);
        check("t1 miso_oe", miso_oe, 1);
        spi_bits(8'h3C, 8, 0, 8'h00, 0, mi);
        ss_high();
        check("t1 master read", mi, 8'hA5);
        check("t1 rx count", rx_q.size(), 1);
        check("t1 rx word", rxw(0), 8'h3C);
        check("t1 tx_ready", tx_ready, 1);
        check("t1 underrun", underrun, 0);
        check("t1 active end", active, 0);
        check("t1 miso_oe end", miso_oe, 0);

        // Back-to-back words, second loaded during the first
        load(8'h12);
        rx_q.delete();
        ss_low();
        spi_bits(8'hF0, 8, 1, 8'h34, 0, mi);
        check("t2 master read w0", mi, 8'h12);
        spi_bits(8'h0F, 8, 0, 8'h00, 0, mi);
        check("t2 master read w1", mi, 8'h34);
        ss_high();
        check("t2 rx count", rx_q.size(), 2);
        check("t2 rx w0", rxw(0), 8'hF0);
        check("t2 rx w1", rxw(1), 8'h0F);
        check("t2 underrun", underrun, 0);

        // Underrun set, clear, then clear colliding with set
        ss_low();
        spi_bits(8'h00, 8, 0, 8'h00, 0, mi);
        ss_high();
        check("t3 master read", mi, 8'h00);
        check("t3 underrun set", underrun, 1);
        pulse_clr();
        check("t3 underrun cleared", underrun, 0);
        ss_low();
        spi_bits(8'h00, 8, 0, 8'h00, 1, mi);
        ss_high();
        check("t3 set beats clr", underrun, 1);
        pulse_clr();

        // Abort after 5 bits, then a clean frame
        rx_q.delete();
        ss_low();
        spi_bits(8'hFF, 5, 0, 8'h00, 0, mi);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t4 no rx_valid", rx_q.size(), 0);
        check("t4 active", active, 0);
        check("t4 miso_oe", miso_oe, 0);
        pulse_clr();
        load(8'hC3);
        ss_low();
        spi_bits(8'h81, 8, 0, 8'h00, 0, mi);
        ss_high();
        check("t4 rx count", rx_q.size(), 1);
        check("t4 rx word", rxw(0), 8'h81);
        check("t4 master read", mi, 8'hC3);

        // Load while full is ignored
        load(8'h55);
        check("t5 tx_ready full", tx_ready, 0);
        load(8'hAA);
        rx_q.delete();
        ss_low();
        spi_bits(8'h66, 8, 0, 8'h00, 0, mi);
        ss_high();
        check("t5 master read", mi, 8'h55);
        check("t5 rx word", rxw(0), 8'h66);

        // Asynchronous reset mid-frame (no load, so underrun is set beforehand)
        rx_q.delete();
        ss_low();
        spi_bits(8'hFF, 3, 0, 8'h00, 0, mi);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        check("t6 pre active", active, 1);
        check("t6 pre underrun", underrun, 1);
        rst = 1'b0;
        #1;
        check("t6 tx_ready", tx_ready, 1);
        check("t6 rx_data", rx_data, 0);
        check("t6 rx_valid", rx_valid, 0);
        check("t6 underrun", underrun, 0);
        check("t6 active", active, 0);
        check("t6 miso", miso, 0);
        check("t6 miso_oe", miso_oe, 0);
        @(negedge clk);
        sclk = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("t6 idle after rst", active, 0);
        load(8'h18);
        ss_low();
        spi_bits(8'h7E, 8, 0, 8'h00, 0, mi);
        ss_high();
        check("t6 rx count", rx_q.size(), 1);
        check("t6 rx word", rxw(0), 8'h7E);
        check("t6 master read", mi, 8'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
